// File: rtl/md_fields_pkg.sv
// Shared metadata field positions and dispatch state encoding for the
// metadata-to-packet dispatcher.
package md_fields_pkg;

   localparam int unsigned META_DISCARD_BIT = 128;
   localparam int unsigned META_DST_PORT_HI = 31;
   localparam int unsigned META_DST_PORT_LO = 24;
   localparam int unsigned META_NEXT_TBL_HI = 255;
   localparam int unsigned META_NEXT_TBL_LO = 250;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } dispatch_state_t;

endpackage

// File: rtl/md_dispatch_fifo.sv
// Synchronous metadata FIFO; a push while full is accepted only when a pop
// frees a slot in the same cycle.
module md_dispatch_fifo #(
   parameter int unsigned WIDTH      = 256,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  push_ok;
   logic                  pop_ok;

   assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         if (push_ok && !pop_ok)
            count <= count + (DEPTH_LOG2+1)'(1);
         else if (!push_ok && pop_ok)
            count <= count - (DEPTH_LOG2+1)'(1);
      end
   end

endmodule

// File: rtl/md_port_dispatch.sv
// Pairs each buffered metadata word with the next AXIS packet: forward with
// tuser = metadata[127:0] or drop on the discard bit. Stats: DISPATCH_STATS_EN.
module md_port_dispatch
   import md_fields_pkg::*;
#(
   parameter int unsigned META_LEN           = 256,
   parameter int unsigned DATA_WIDTH         = 256,
   parameter int unsigned TUSER_WIDTH        = 128,
   parameter int unsigned MD_FIFO_DEPTH_LOG2 = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [META_LEN-1:0]       comp_meta_data_in,
   input  logic                      comp_meta_data_valid_in,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                      s_axis_tlast,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      md_overflow,
   output logic [31:0]               drop_cnt,
   output logic [31:0]               fwd_cnt
);

   dispatch_state_t     state, state_nxt;
   logic [META_LEN-1:0] head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                pop;
   logic                fwd_done;
   logic                drop_done;
   logic                unused_meta;

   // Pop only when a packet is actually waiting, so early metadata stays queued.
   assign pop = (state == ST_IDLE) && !fifo_empty && s_axis_tvalid;

   md_dispatch_fifo #(
      .WIDTH      (META_LEN),
      .DEPTH_LOG2 (MD_FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (comp_meta_data_valid_in),
      .push_data (comp_meta_data_in),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tkeep = s_axis_tkeep;
   assign m_axis_tlast = s_axis_tlast;

   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      fwd_done      = 1'b0;
      drop_done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pop) state_nxt = head[META_DISCARD_BIT] ? ST_DROP : ST_FWD;
         end
         ST_FWD: begin
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
               fwd_done  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               drop_done = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         m_axis_tuser <= '0;
         md_overflow  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) m_axis_tuser <= head[TUSER_WIDTH-1:0];
         if (comp_meta_data_valid_in && fifo_full && !pop) md_overflow <= 1'b1;
      end
   end

`ifdef DISPATCH_STATS_EN
   logic [31:0] drop_q;
   logic [31:0] fwd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= '0;
         fwd_q  <= '0;
      end else begin
         if (drop_done) drop_q <= drop_q + 32'd1;
         if (fwd_done)  fwd_q  <= fwd_q + 32'd1;
      end
   end

   assign drop_cnt    = drop_q;
   assign fwd_cnt     = fwd_q;
   assign unused_meta = ^head[META_LEN-1:META_DISCARD_BIT+1];
`else
   assign drop_cnt    = '0;
   assign fwd_cnt     = '0;
   assign unused_meta = ^{head[META_LEN-1:META_DISCARD_BIT+1], fwd_done, drop_done};
`endif

endmodule

// File: tb/tb_md_port_dispatch.sv
// Directed bench for md_port_dispatch: scoreboard of expected output beats,
// checked by immediate assertions; counter checks follow DISPATCH_STATS_EN.
module tb_md_port_dispatch;

   typedef struct {
      logic [255:0] d;
      logic [31:0]  k;
      logic         l;
      logic [127:0] u;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] comp_meta_data_in;
   logic         comp_meta_data_valid_in;
   logic [255:0] s_axis_tdata;
   logic [31:0]  s_axis_tkeep;
   logic         s_axis_tlast;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [255:0] m_axis_tdata;
   logic [31:0]  m_axis_tkeep;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tlast;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic         md_overflow;
   logic [31:0]  drop_cnt;
   logic [31:0]  fwd_cnt;

   int    tests = 0;
   int    fails = 0;
   int    exp_fwd = 0;
   int    exp_drop = 0;
   bit    tog = 1'b0;
   beat_t sb[$];

   md_port_dispatch #(
      .META_LEN           (256),
      .DATA_WIDTH         (256),
      .TUSER_WIDTH        (128),
      .MD_FIFO_DEPTH_LOG2 (2)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .comp_meta_data_in       (comp_meta_data_in),
      .comp_meta_data_valid_in (comp_meta_data_valid_in),
      .s_axis_tdata            (s_axis_tdata),
      .s_axis_tkeep            (s_axis_tkeep),
      .s_axis_tlast            (s_axis_tlast),
      .s_axis_tvalid           (s_axis_tvalid),
      .s_axis_tready           (s_axis_tready),
      .m_axis_tdata            (m_axis_tdata),
      .m_axis_tkeep            (m_axis_tkeep),
      .m_axis_tuser            (m_axis_tuser),
      .m_axis_tlast            (m_axis_tlast),
      .m_axis_tvalid           (m_axis_tvalid),
      .m_axis_tready           (m_axis_tready),
      .md_overflow             (md_overflow),
      .drop_cnt                (drop_cnt),
      .fwd_cnt                 (fwd_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tog) begin
         #1 m_axis_tready = ~m_axis_tready;
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (rst_n === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
         check("out_beat_expected", 256'(sb.size() != 0), 256'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_tdata", m_axis_tdata, e.d);
            check("out_tkeep", 256'(m_axis_tkeep), 256'(e.k));
            check("out_tlast", 256'(m_axis_tlast), 256'(e.l));
            check("out_tuser", 256'(m_axis_tuser), 256'(e.u));
         end
      end
   end

   function automatic logic [255:0] mk_md(input bit disc, input logic [7:0] dst, input logic [31:0] tag);
      logic [255:0] m;
      for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
      m[128]     = disc;
      m[127:32]  = {tag, tag, tag};
      m[31:24]   = dst;
      m[23:0]    = tag[23:0];
      return m;
   endfunction

   task automatic drive_md(input logic [255:0] m);
      comp_meta_data_in       = m;
      comp_meta_data_valid_in = 1'b1;
      @(posedge clk);
      #1;
      comp_meta_data_valid_in = 1'b0;
   endtask

   task automatic beat_val(input int id, input int i, input int nb,
                           output logic [255:0] d, output logic [31:0] k);
      logic [15:0] a, b;
      a = id[15:0];
      b = i[15:0];
      d = {8{a, b}};
      k = (i == nb - 1) ? 32'h0000_ffff : 32'hffff_ffff;
   endtask

   task automatic send_packet(input int nb, input int id, input bit fwd,
                              input logic [127:0] u, output int first_wait);
      logic [255:0] d;
      logic [31:0]  k;
      int  waits;
      bit  acc;
      first_wait = -1;
      for (int i = 0; i < nb; i++) begin
         beat_val(id, i, nb, d, k);
         s_axis_tdata  = d;
         s_axis_tkeep  = k;
         s_axis_tlast  = (i == nb - 1);
         s_axis_tvalid = 1'b1;
         if (fwd) sb.push_back('{d: d, k: k, l: (i == nb - 1), u: u});
         waits = 0;
         acc   = 1'b0;
         while (!acc && waits < 200) begin
            @(negedge clk);
            acc = s_axis_tready;
            if (!fwd) check("drop_no_valid", 256'(m_axis_tvalid), 256'(0));
            @(posedge clk);
            #1;
            if (!acc) waits++;
         end
         if (!acc) check("beat_accept_timeout", 256'(0), 256'(1));
         if (i == 0) first_wait = waits;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (fwd) exp_fwd++;
      else     exp_drop++;
   endtask

   task automatic check_cnts(input string tag);
      int ef, ed;
`ifdef DISPATCH_STATS_EN
      ef = exp_fwd;
      ed = exp_drop;
`else
      ef = 0;
      ed = 0;
`endif
      check({tag, "_fwd_cnt"}, 256'(fwd_cnt), 256'(ef));
      check({tag, "_drop_cnt"}, 256'(drop_cnt), 256'(ed));
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] m;
      logic [255:0] mds [5];
      logic [127:0] u;
      logic [255:0] d;
      logic [31:0]  k;
      int fw;
      bit acc;
      int waits;

      rst_n                   = 1'b0;
      comp_meta_data_in       = '0;
      comp_meta_data_valid_in = 1'b0;
      s_axis_tdata            = '0;
      s_axis_tkeep            = '0;
      s_axis_tlast            = 1'b0;
      s_axis_tvalid           = 1'b0;
      m_axis_tready           = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
      check("rst_s_tready", 256'(s_axis_tready), 256'(0));
      check("rst_m_tuser", 256'(m_axis_tuser), 256'(0));
      check("rst_md_overflow", 256'(md_overflow), 256'(0));
      check_cnts("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 3-beat forward, one bubble
      m = mk_md(1'b0, 8'h04, 32'h0000_0011);
      u = m[127:0];
      drive_md(m);
      send_packet(3, 1, 1'b1, u, fw);
      check("t1_bubble", 256'(fw), 256'(1));
      check_cnts("t1");

      // 2-beat drop
      m = mk_md(1'b1, 8'h22, 32'h0000_0022);
      drive_md(m);
      send_packet(2, 2, 1'b0, m[127:0], fw);
      check("t2_bubble", 256'(fw), 256'(1));
      check_cnts("t2");

      // data 5 cycles before metadata
      m = mk_md(1'b0, 8'h33, 32'h0000_0033);
      u = m[127:0];
      fork
         send_packet(2, 3, 1'b1, u, fw);
         begin
            repeat (5) @(posedge clk);
            #1;
            drive_md(m);
         end
      join
      check("t3_wait_for_md", 256'(fw), 256'(7));
      check_cnts("t3");

      // overflow: five strobes into depth 4
      for (int i = 0; i < 5; i++) begin
         mds[i] = mk_md(1'b0, 8'(8'h41 + i), 32'(32'h0000_0041 + i));
         drive_md(mds[i]);
         if (i == 3) check("t4_no_ovf_at_full", 256'(md_overflow), 256'(0));
      end
      check("t4_ovf_set", 256'(md_overflow), 256'(1));
      for (int i = 0; i < 4; i++) begin
         send_packet(1, 16 + i, 1'b1, mds[i][127:0], fw);
         check("t4_bubble", 256'(fw), 256'(1));
      end
      check_cnts("t4");

      // alternating discard, single beats, tready toggling
      for (int i = 0; i < 4; i++) begin
         mds[i] = mk_md(i[0], i[0] ? 8'h10 : 8'h01, 32'(32'h0000_0050 + i));
         drive_md(mds[i]);
      end
      tog = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_packet(1, 32 + i, !mds[i][128], mds[i][127:0], fw);
      end
      tog = 1'b0;
      @(posedge clk);
      #2;
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      check("t5_sb_empty", 256'(sb.size()), 256'(0));
      check_cnts("t5");

      // reset mid-packet in FWD, with a spare metadata word queued
      m = mk_md(1'b0, 8'h66, 32'h0000_0066);
      u = m[127:0];
      drive_md(m);
      drive_md(mk_md(1'b0, 8'h77, 32'h0000_0077));
      beat_val(6, 0, 3, d, k);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      sb.push_back('{d: d, k: k, l: 1'b0, u: u});
      waits = 0;
      acc   = 1'b0;
      while (!acc && waits < 50) begin
         @(negedge clk);
         acc = s_axis_tready;
         @(posedge clk);
         #1;
         if (!acc) waits++;
      end
      check("t6_first_beat_accepted", 256'(acc), 256'(1));
      beat_val(6, 1, 3, d, k);
      s_axis_tdata = d;
      s_axis_tkeep = k;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_m_tvalid", 256'(m_axis_tvalid), 256'(0));
      check("t6_async_s_tready", 256'(s_axis_tready), 256'(0));
      check("t6_async_tuser", 256'(m_axis_tuser), 256'(0));
      check("t6_async_ovf", 256'(md_overflow), 256'(0));
      exp_fwd  = 0;
      exp_drop = 0;
      check_cnts("t6_async");
      s_axis_tvalid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // pending packet must stall: FIFO flushed, machine idle
      beat_val(8, 0, 1, d, k);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t6_flushed_stall", 256'(s_axis_tready), 256'(0));
         @(posedge clk);
         #1;
      end
      m = mk_md(1'b0, 8'h88, 32'h0000_0088);
      drive_md(m);
      send_packet(1, 8, 1'b1, m[127:0], fw);
      check("t6_after_reset_bubble", 256'(fw), 256'(1));
      check_cnts("t6_end");

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 256'(sb.size()), 256'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
